// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, state encoding and datapath functions
// (S-box layer, bit permutation, round key addition).
package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int RC_W    = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } core_state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int n = 0; n < BLOCK_W / 4; n++) begin
      y[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit i lands on (i*16) mod 63; the top bit is a fixed point.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < BLOCK_W - 1; i++) begin
      y[(i * 16) % 63] = x[i];
    end
    y[BLOCK_W-1] = x[BLOCK_W-1];
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] key_add(input logic [BLOCK_W-1:0] s,
                                                 input logic [KEY_W-1:0]   k);
    return s ^ k[KEY_W-1:KEY_W-BLOCK_W];
  endfunction

endpackage

// File: rtl/present_round_core_if.sv
// Start/done bundle between a requester (master) and the PRESENT core (slave).
interface present_round_core_if;
  import present_pkg::*;

  // start is a request sampled only while busy is low; plaintext and key
  // travel with it. busy rises on the accepting edge and falls on the edge
  // that raises done for exactly one cycle; ciphertext then holds until the
  // next completion. start is ignored while busy is high.
  logic               start;
  logic [BLOCK_W-1:0] plaintext;
  logic [KEY_W-1:0]   key;
  logic               busy;
  logic               done;
  logic [BLOCK_W-1:0] ciphertext;
  core_state_e        fsmState;

  modport master (
    output start, plaintext, key,
    input  busy, done, ciphertext, fsmState
  );

  modport slave (
    input  start, plaintext, key,
    output busy, done, ciphertext, fsmState
  );

endinterface

// File: rtl/present_key_update.sv
// Combinational PRESENT-80 key schedule step: rotate, S-box top nibble, fold in rc.
module present_key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] keyIn,
  input  logic [RC_W-1:0]  rc,
  output logic [KEY_W-1:0] keyOut
);

  logic [KEY_W-1:0] rotKey;

  // Left rotation by 61 is the same as right rotation by 19.
  assign rotKey = {keyIn[18:0], keyIn[79:19]};

  assign keyOut = {sbox4(rotKey[79:76]),
                   rotKey[75:20],
                   rotKey[19:15] ^ rc,
                   rotKey[14:0]};

endmodule

// File: rtl/present_round_core.sv
// Iterative PRESENT-80 encryption, one round per clock, start/done handshake.
// Define PRESENT_DBG_EN to expose the state register and round counter.
module present_round_core
  import present_pkg::*;
#(
  parameter int unsigned ROUNDS = 31
) (
  input  logic clk,
  input  logic rst,
  present_round_core_if.slave bus
`ifdef PRESENT_DBG_EN
  ,
  output logic [BLOCK_W-1:0] dbg_state,
  output logic [RC_W-1:0]    dbg_round
`endif
);

  // rc carries one extra bit so the terminal value ROUNDS+1 (32) is representable.
  localparam logic [RC_W:0] RC_LAST = (RC_W + 1)'(ROUNDS + 1);

  core_state_e        curState;
  core_state_e        nxtState;
  logic               loadEn;
  logic               roundEn;
  logic               finishEn;
  logic               lastRound;
  logic [BLOCK_W-1:0] stateReg;
  logic [KEY_W-1:0]   keyReg;
  logic [KEY_W-1:0]   keyNext;
  logic [RC_W:0]      rc;
  logic [BLOCK_W-1:0] ctReg;
  logic               doneReg;

  assign lastRound = (rc == RC_LAST);

  present_key_update u_key_update (
    .keyIn  (keyReg),
    .rc     (rc[RC_W-1:0]),
    .keyOut (keyNext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) curState <= ST_IDLE;
    else     curState <= nxtState;
  end

  always_comb begin
    nxtState = curState;
    case (curState)
      ST_IDLE: if (bus.start) nxtState = ST_RUN;
      ST_RUN:  if (lastRound) nxtState = ST_IDLE;
      default: nxtState = ST_IDLE;
    endcase
  end

  always_comb begin
    loadEn   = 1'b0;
    roundEn  = 1'b0;
    finishEn = 1'b0;
    case (curState)
      ST_IDLE: loadEn = bus.start;
      ST_RUN: begin
        roundEn  = !lastRound;
        finishEn = lastRound;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= '0;
      keyReg   <= '0;
      rc       <= '0;
      ctReg    <= '0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= finishEn;
      if (loadEn) begin
        stateReg <= bus.plaintext;
        keyReg   <= bus.key;
        rc       <= (RC_W + 1)'(1);
      end else if (roundEn) begin
        stateReg <= p_layer(sbox_layer(key_add(stateReg, keyReg)));
        keyReg   <= keyNext;
        rc       <= rc + (RC_W + 1)'(1);
      end
      if (finishEn) ctReg <= key_add(stateReg, keyReg);
    end
  end

  assign bus.busy       = (curState == ST_RUN);
  assign bus.done       = doneReg;
  assign bus.ciphertext = ctReg;
  assign bus.fsmState   = curState;

`ifdef PRESENT_DBG_EN
  assign dbg_state = stateReg;
  assign dbg_round = rc[RC_W-1:0];
`endif

endmodule

// File: tb/tb_present_round_core.sv
// Self-checking bench for present_round_core: known vectors, handshake corner
// cases and randomized blocks against a behavioural PRESENT-80 model.
module tb_present_round_core;
  import present_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  present_round_core_if bus ();

`ifdef PRESENT_DBG_EN
  logic [63:0] dbg_state;
  logic [4:0]  dbg_round;
`endif

  present_round_core #(.ROUNDS(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PRESENT_DBG_EN
    ,
    .dbg_state (dbg_state),
    .dbg_round (dbg_round)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_encrypt(input logic [63:0] m, input logic [79:0] k);
    int          sb[16];
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] kk;
    logic [4:0]  rcv;
    sb = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    s  = m;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
      s = '0;
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (i * 16) % 63] = t[i];
      kk = (kk << 61) | (kk >> 19);
      kk[79:76] = 4'(sb[kk[79:76]]);
      rcv = 5'(r);
      kk[19:15] = kk[19:15] ^ rcv;
    end
    return s ^ kk[79:16];
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic start_enc(input logic [63:0] m, input logic [79:0] k, input logic [63:0] exp);
    bus.start     = 1'b1;
    bus.plaintext = m;
    bus.key       = k;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // lat counts edges after the accepting edge; pulse_at injects a start while busy.
  task automatic wait_done(input string tag, input int pulse_at, output int busy_cnt);
    int          lat;
    logic [63:0] exp;
    lat      = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 64) begin
      if (bus.busy) busy_cnt++;
      if (lat == pulse_at) begin
        bus.start     = 1'b1;
        bus.plaintext = {$urandom, $urandom};
        bus.key       = {$urandom, $urandom, 16'($urandom_range(0, 65535))};
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    exp = exp_q.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'd32);
    if (bus.done) begin
      check({tag, "_ct"}, bus.ciphertext, exp);
      check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          bc;
    int          nd;
    logic [63:0] m;
    logic [79:0] k;

    bus.start     = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;

    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ct", bus.ciphertext, 64'd0);
`ifdef PRESENT_DBG_EN
    check("rst_dbg_state", dbg_state, 64'd0);
    check("rst_dbg_round", 64'(dbg_round), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Known-answer vectors
    @(negedge clk);
    start_enc(64'h0, 80'h0, 64'h5579C1387B228445);
    wait_done("kat_zero", -1, bc);
    check("kat_zero_busy_len", 64'(bc), 64'd32);
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("ct_hold", bus.ciphertext, 64'h5579C1387B228445);

    start_enc(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
    wait_done("kat_key_ones", -1, bc);

    @(negedge clk);
    start_enc({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B);
    wait_done("kat_pt_ones", -1, bc);
    // back-to-back: start on the edge right after done
    start_enc({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);
    wait_done("kat_b2b", -1, bc);

    // start while busy is ignored
    @(negedge clk);
    m = {$urandom, $urandom};
    k = {$urandom, $urandom, 16'($urandom_range(0, 65535))};
    start_enc(m, k, ref_encrypt(m, k));
    wait_done("busy_start", 9, bc);
    check("busy_start_busy_len", 64'(bc), 64'd32);
    count_done(40, nd);
    check("busy_start_extra_done", 64'(nd), 64'd0);
    check("busy_start_idle", 64'(bus.busy), 64'd0);

    // reset in the middle of an encryption
    start_enc(64'h0123456789ABCDEF, 80'h0, ref_encrypt(64'h0123456789ABCDEF, 80'h0));
    void'(exp_q.pop_front());
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_ct", bus.ciphertext, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(40, nd);
    check("abort_no_done", 64'(nd), 64'd0);
    start_enc(64'h0, 80'h0, 64'h5579C1387B228445);
    wait_done("after_abort", -1, bc);

    // randomized blocks against the model
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      m = {$urandom, $urandom};
      k = {$urandom, $urandom, 16'($urandom_range(0, 65535))};
      start_enc(m, k, ref_encrypt(m, k));
      wait_done("rand", -1, bc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
